pagerank_worker: RTL and testbench

PAGERANK_WORKER -- requirements
Module: pagerank_worker

---
 rtl/pagerank_pkg.sv | 7 +
 rtl/pagerank_if.sv | 20 ++
 rtl/pagerank_mac.sv | 15 +
 rtl/pagerank_worker.sv | 80 ++++++++
 tb/tb_pagerank_worker.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pagerank_pkg.sv
// pagerank_pkg: state encoding and constants shared by the PageRank worker and scheduler
package pagerank_pkg;
  typedef enum logic [3:0] {IDLE, RD_G, WT_G, RD_R, WT_R, MAC, WR, WT_WR, DONE} state_t;
  localparam logic MEM_READ = 1'b0;
  localparam logic MEM_WRITE = 1'b1;
  localparam int FRAC_BITS = 16;
endpackage

// File: rtl/pagerank_if.sv
// pagerank_if: job and memory handshake bundle between a worker and its scheduler/memory
interface pagerank_if #(parameter int nbits = 32);
  logic job_req_val, job_req_rdy;
  logic [31:0] job_req_node;
  logic job_resp_val, job_resp_rdy;
  logic [nbits-1:0] job_resp_data;
  logic mem_req_val, mem_req_rdy, mem_req_type;
  logic [31:0] mem_req_addr;
  logic [nbits-1:0] mem_req_data;
  logic mem_resp_val, mem_resp_rdy, mem_resp_type;
  logic [nbits-1:0] mem_resp_data;
  modport master (
    input job_req_val, job_req_node, job_resp_rdy, mem_req_rdy, mem_resp_val, mem_resp_type, mem_resp_data,
    output job_req_rdy, job_resp_val, job_resp_data, mem_req_val, mem_req_type, mem_req_addr, mem_req_data, mem_resp_rdy
  );
  modport slave (
    output job_req_val, job_req_node, job_resp_rdy, mem_req_rdy, mem_resp_val, mem_resp_type, mem_resp_data,
    input job_req_rdy, job_resp_val, job_resp_data, mem_req_val, mem_req_type, mem_req_addr, mem_req_data, mem_resp_rdy
  );
endinterface

// File: rtl/pagerank_mac.sv
// pagerank_mac: Q16.16 multiply-accumulate holding the running rank sum
module pagerank_mac import pagerank_pkg::*; #(parameter int nbits = 32) (
  input logic clk,
  input logic reset,
  input logic clr,
  input logic en,
  input logic [nbits-1:0] g,
  input logic [nbits-1:0] r,
  output logic [nbits-1:0] acc
);
  logic signed [2*nbits-1:0] prod;
  assign prod = $signed(g) * $signed(r);
  // add the rescaled full-width product, wrapping at the word width
  always_ff @(posedge clk) acc <= (!reset || clr) ? '0 : en ? acc + nbits'(prod >>> FRAC_BITS) : acc;
endmodule

// File: rtl/pagerank_worker.sv
// pagerank_worker: computes one node's new rank as the fixed-point dot product of its G row with R
module pagerank_worker import pagerank_pkg::*; #(
  parameter int nbits = 32,
  parameter int nnodes = 8
) (
  input logic clk,
  input logic reset,
  input logic [31:0] cfg_g_base,
  input logic [31:0] cfg_r_base,
  input logic [31:0] cfg_o_base,
  pagerank_if.master bus
);
  localparam int cw = $clog2(nnodes) + 1;
  state_t state, state_nxt;
  logic live, job_go, last, unused_resp_type;
  logic [cw-1:0] i, j;
  logic [nbits-1:0] g, r, acc;
  logic [31:0] g_addr, r_addr, o_addr;
  assign unused_resp_type = bus.mem_resp_type;
  assign job_go = bus.job_req_val && bus.job_req_rdy;
  assign last = j == cw'(nnodes - 1);
  assign g_addr = cfg_g_base + ((32'(i) * 32'(nnodes) + 32'(j)) << 2);
  assign r_addr = cfg_r_base + (32'(j) << 2);
  assign o_addr = cfg_o_base + (32'(i) << 2);
  pagerank_mac #(.nbits(nbits)) u_mac (
    .clk(clk),
    .reset(reset),
    .clr(job_go),
    .en(state == MAC),
    .g(g),
    .r(r),
    .acc(acc)
  );
  // state register; live keeps job_req_rdy low for the cycle following a reset edge
  always_ff @(posedge clk) begin
    state <= reset ? state_nxt : IDLE;
    live <= reset;
  end
  // node index, loop counter and operands captured from memory responses
  always_ff @(posedge clk) begin
    if (!reset) begin
      i <= '0;
      j <= '0;
      g <= '0;
      r <= '0;
    end else begin
      if (job_go) begin
        i <= cw'(bus.job_req_node);
        j <= '0;
      end
      if (state == MAC) j <= j + 1'b1;
      if (state == WT_G && bus.mem_resp_val) g <= bus.mem_resp_data;
      if (state == WT_R && bus.mem_resp_val) r <= bus.mem_resp_data;
    end
  end
  // next state and Moore outputs; payloads are zero outside the states that present them
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (job_go) state_nxt = bus.job_req_node < 32'(nnodes) ? RD_G : DONE;
      RD_G: if (bus.mem_req_rdy) state_nxt = WT_G;
      WT_G: if (bus.mem_resp_val) state_nxt = RD_R;
      RD_R: if (bus.mem_req_rdy) state_nxt = WT_R;
      WT_R: if (bus.mem_resp_val) state_nxt = MAC;
      MAC: state_nxt = last ? WR : RD_G;
      WR: if (bus.mem_req_rdy) state_nxt = WT_WR;
      WT_WR: if (bus.mem_resp_val) state_nxt = DONE;
      DONE: if (bus.job_resp_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    bus.job_req_rdy = live && state == IDLE;
    bus.mem_req_val = state inside {RD_G, RD_R, WR};
    bus.mem_resp_rdy = state inside {WT_G, WT_R, WT_WR};
    bus.job_resp_val = state == DONE;
    bus.job_resp_data = state == DONE ? acc : '0;
    bus.mem_req_type = state == WR ? MEM_WRITE : MEM_READ;
    bus.mem_req_data = state == WR ? acc : '0;
    bus.mem_req_addr = state == RD_G ? g_addr : state == RD_R ? r_addr : state == WR ? o_addr : '0;
  end
endmodule

// File: tb/tb_pagerank_worker.sv
// tb_pagerank_worker: randomized and directed checks of the worker against a dot-product model
module tb_pagerank_worker;
  localparam int N = 4;
  localparam logic [31:0] G_BASE = 32'h100;
  localparam logic [31:0] R_BASE = 32'h200;
  localparam logic [31:0] O_BASE = 32'h300;
  localparam int G_W = 64;
  localparam int R_W = 128;
  logic clk = 0;
  logic reset = 0;
  always #5 clk = ~clk;
  pagerank_if #(.nbits(32)) bus();
  pagerank_worker #(.nbits(32), .nnodes(N)) dut (
    .clk(clk),
    .reset(reset),
    .cfg_g_base(G_BASE),
    .cfg_r_base(R_BASE),
    .cfg_o_base(O_BASE),
    .bus(bus)
  );
  logic [31:0] mem [0:255];
  bit stall_mode = 0;
  int stall_cycles = 0;
  int stall_viol = 0;
  logic [31:0] req_addr_q[$];
  logic [31:0] req_data_q[$];
  logic req_type_q[$];
  int checks = 0;
  int errors = 0;

  // memory: answers each request one cycle after it transfers; optional 5-cycle stall before each request
  initial begin
    bit rq, rs, rn, hold;
    logic [31:0] qa, qd, ha, hd;
    logic qt, ht;
    int wc;
    hold = 0; wc = 0; ha = '0; hd = '0; ht = 0;
    bus.mem_req_rdy = 1; bus.mem_resp_val = 0; bus.mem_resp_type = 0; bus.mem_resp_data = '0;
    forever begin
      @(negedge clk);
      rn = reset;
      rq = bus.mem_req_val && bus.mem_req_rdy;
      rs = bus.mem_resp_val && bus.mem_resp_rdy;
      qa = bus.mem_req_addr; qd = bus.mem_req_data; qt = bus.mem_req_type;
      if (bus.mem_req_val) begin
        if (hold && {ha, hd, ht} !== {qa, qd, qt}) stall_viol++;
        if (!bus.mem_req_rdy) stall_cycles++;
        hold = 1; ha = qa; hd = qd; ht = qt;
      end
      @(posedge clk); #1;
      if (rs || !rn) bus.mem_resp_val = 0;
      if (rq || !rn) hold = 0;
      if (rq && rn) begin
        req_addr_q.push_back(qa); req_data_q.push_back(qd); req_type_q.push_back(qt);
        bus.mem_resp_val = 1; bus.mem_resp_type = qt;
        bus.mem_resp_data = qt ? 32'h0 : mem[qa[9:2]];
      end
      if (!stall_mode) begin bus.mem_req_rdy = 1; wc = 0; end
      else if (!bus.mem_req_val) begin bus.mem_req_rdy = 0; wc = 0; end
      else if (!bus.mem_req_rdy) begin
        if (wc == 5) bus.mem_req_rdy = 1;
        else wc++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model_rank(int i);
    logic [31:0] acc = 0;
    for (int j = 0; j < N; j++) begin
      longint p = longint'($signed(mem[G_W + i * N + j])) * longint'($signed(mem[R_W + j]));
      acc = acc + 32'(p >>> 16);
    end
    return acc;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_example();
    for (int k = 0; k < 256; k++) mem[k] = $urandom;
    mem[G_W + 4] = 32'h8000; mem[G_W + 5] = 0; mem[G_W + 6] = 32'h8000; mem[G_W + 7] = 0;
    mem[R_W + 0] = 32'h4000; mem[R_W + 1] = 32'h10000; mem[R_W + 2] = 32'hC000; mem[R_W + 3] = 0;
  endtask

  task automatic run_job(input logic [31:0] node, output logic [31:0] data, output int lat);
    int k;
    tick();
    bus.job_req_val = 1; bus.job_req_node = node;
    k = 0;
    @(negedge clk);
    while (!bus.job_req_rdy && k < 100) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    bus.job_req_val = 0;
    lat = 1;
    @(negedge clk);
    while (!bus.job_resp_val && lat < 2000) begin @(negedge clk); lat++; end
    data = bus.job_resp_data;
  endtask

  task automatic test_reset();
    logic [100:0] o;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (k == 2) reset = 1;
      @(negedge clk);
      o = {bus.job_req_rdy, bus.job_resp_val, bus.mem_req_val, bus.mem_resp_rdy, bus.mem_req_type,
           bus.mem_req_addr, bus.mem_req_data, bus.job_resp_data};
      checks++;
      if (o !== '0) begin errors++; $display("FAIL reset_outputs_%0d got %h want 0", k, o); end
    end
    @(negedge clk);
    checks++;
    if (bus.job_req_rdy !== 1'b1) begin errors++; $display("FAIL reset_release_rdy got %b want 1", bus.job_req_rdy); end
  endtask

  task automatic test_example();
    logic [31:0] d;
    int lat, base, bad;
    load_example();
    base = req_addr_q.size();
    run_job(1, d, lat);
    checks++;
    if (d !== 32'h8000) begin errors++; $display("FAIL example_data got %h want 00008000", d); end
    checks++;
    if (lat !== 5 * N + 3) begin errors++; $display("FAIL example_latency got %0d want %0d", lat, 5 * N + 3); end
    checks++;
    if (req_addr_q.size() - base !== 2 * N + 1) begin
      errors++; $display("FAIL example_req_count got %0d want %0d", req_addr_q.size() - base, 2 * N + 1);
    end
    bad = 0;
    for (int j = 0; j < N; j++) begin
      if (req_addr_q[base + 2 * j] !== G_BASE + 32'(4 * (N + j)) || req_type_q[base + 2 * j] !== 1'b0) bad++;
      if (req_addr_q[base + 2 * j + 1] !== R_BASE + 32'(4 * j) || req_type_q[base + 2 * j + 1] !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL example_read_addrs got %0d bad want 0", bad); end
    checks++;
    if ({req_type_q[base + 2 * N], req_addr_q[base + 2 * N], req_data_q[base + 2 * N]} !== {1'b1, O_BASE + 32'd4, 32'h8000}) begin
      errors++;
      $display("FAIL example_write got %b %h %h want 1 %h 00008000", req_type_q[base + 2 * N],
               req_addr_q[base + 2 * N], req_data_q[base + 2 * N], O_BASE + 32'd4);
    end
  endtask

  task automatic test_stall();
    logic [31:0] d;
    int lat, s0, v0, base;
    load_example();
    stall_mode = 1;
    s0 = stall_cycles; v0 = stall_viol; base = req_addr_q.size();
    run_job(1, d, lat);
    checks++;
    if (d !== 32'h8000) begin errors++; $display("FAIL stall_data got %h want 00008000", d); end
    checks++;
    if (lat !== 5 * N + 3 + 5 * (2 * N + 1)) begin errors++; $display("FAIL stall_latency got %0d want %0d", lat, 5 * N + 3 + 5 * (2 * N + 1)); end
    checks++;
    if (stall_cycles - s0 !== 5 * (2 * N + 1)) begin errors++; $display("FAIL stall_cycles got %0d want %0d", stall_cycles - s0, 5 * (2 * N + 1)); end
    checks++;
    if (stall_viol - v0 !== 0) begin errors++; $display("FAIL stall_payload_stable got %0d changes want 0", stall_viol - v0); end
    checks++;
    if (req_data_q[req_data_q.size() - 1] !== 32'h8000 || req_addr_q.size() - base !== 2 * N + 1) begin
      errors++; $display("FAIL stall_write got %h want 00008000", req_data_q[req_data_q.size() - 1]);
    end
    stall_mode = 0;
  endtask

  task automatic test_invalid();
    logic [31:0] d, node;
    int lat, base;
    for (int k = 0; k < 2; k++) begin
      node = k == 0 ? N : $urandom_range(N + 1, 32'h7fff_ffff);
      base = req_addr_q.size();
      run_job(node, d, lat);
      checks++;
      if ({lat, d} !== {32'd1, 32'd0}) begin errors++; $display("FAIL invalid_%0d got lat %0d data %h want lat 1 data 0", node, lat, d); end
      checks++;
      if (req_addr_q.size() !== base) begin errors++; $display("FAIL invalid_mem_reqs got %0d want 0", req_addr_q.size() - base); end
    end
  endtask

  task automatic test_resp_hold();
    logic [31:0] d;
    int lat;
    load_example();
    tick();
    bus.job_resp_rdy = 0;
    run_job(1, d, lat);
    checks++;
    if (d !== 32'h8000) begin errors++; $display("FAIL hold_data got %h want 00008000", d); end
    for (int k = 0; k < 10; k++) begin
      tick();
      @(negedge clk);
      checks++;
      if ({bus.job_resp_val, bus.job_resp_data, bus.job_req_rdy} !== {1'b1, 32'h8000, 1'b0}) begin
        errors++;
        $display("FAIL hold_cycle_%0d got val %b data %h req_rdy %b want 1 00008000 0", k, bus.job_resp_val, bus.job_resp_data, bus.job_req_rdy);
      end
    end
    tick();
    bus.job_resp_rdy = 1;
    tick();
    @(negedge clk);
    checks++;
    if ({bus.job_resp_val, bus.job_req_rdy} !== 2'b01) begin
      errors++; $display("FAIL hold_release got val %b req_rdy %b want 0 1", bus.job_resp_val, bus.job_req_rdy);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [100:0] o;
    int lat, n, k;
    load_example();
    tick();
    bus.job_req_val = 1; bus.job_req_node = 1;
    @(negedge clk);
    k = 0;
    while (!bus.job_req_rdy && k < 100) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    bus.job_req_val = 0;
    n = 0; k = 0;
    while (n < 2 && k < 200) begin
      @(negedge clk);
      if (bus.mem_req_val && bus.mem_req_rdy) n++;
      k++;
    end
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    checks++;
    if (bus.mem_resp_rdy !== 1'b1) begin errors++; $display("FAIL midreset_in_wait got %b want 1", bus.mem_resp_rdy); end
    tick();
    reset = 1;
    @(negedge clk);
    o = {bus.job_req_rdy, bus.job_resp_val, bus.mem_req_val, bus.mem_resp_rdy, bus.mem_req_type,
         bus.mem_req_addr, bus.mem_req_data, bus.job_resp_data};
    checks++;
    if (o !== '0) begin errors++; $display("FAIL midreset_outputs got %h want 0", o); end
    @(negedge clk);
    checks++;
    if (bus.job_req_rdy !== 1'b1) begin errors++; $display("FAIL midreset_idle got %b want 1", bus.job_req_rdy); end
    run_job(1, d, lat);
    checks++;
    if ({d, lat} !== {32'h8000, 32'(5 * N + 3)}) begin errors++; $display("FAIL midreset_rejob got %h lat %0d want 00008000 lat %0d", d, lat, 5 * N + 3); end
  endtask

  task automatic test_random();
    logic [31:0] d, exp;
    int lat, i;
    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < 256; k++) mem[k] = $urandom;
      if (t < 2) for (int k = 0; k < N; k++) mem[R_W + k] = $urandom_range(0, 32'h2_0000);
      i = $urandom_range(0, N - 1);
      exp = model_rank(i);
      run_job(i, d, lat);
      checks++;
      if (d !== exp) begin errors++; $display("FAIL random_%0d_data node %0d got %h want %h", t, i, d, exp); end
      checks++;
      if (lat !== 5 * N + 3) begin errors++; $display("FAIL random_%0d_latency got %0d want %0d", t, lat, 5 * N + 3); end
      checks++;
      if ({req_addr_q[req_addr_q.size() - 1], req_data_q[req_data_q.size() - 1]} !== {O_BASE + 32'(4 * i), exp}) begin
        errors++;
        $display("FAIL random_%0d_write got %h %h want %h %h", t, req_addr_q[req_addr_q.size() - 1],
                 req_data_q[req_data_q.size() - 1], O_BASE + 32'(4 * i), exp);
      end
    end
  endtask

  initial begin
    bus.job_req_val = 0; bus.job_req_node = 0; bus.job_resp_rdy = 1;
    test_reset();
    test_example();
    test_stall();
    test_invalid();
    test_resp_hold();
    test_reset_mid();
    test_random();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
